// File: rtl/seq_signed_divider.sv
// Sequential 16-bit signed divider: restoring radix-2, one quotient bit per cycle.
// Truncating semantics; divide-by-zero yields all-ones quotient and flags it.
module seq_signed_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] prem_q, prem_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] dmag_q, dmag_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    logic [15:0] a_mag, b_mag;
    logic [16:0] shifted, diff;

    always_comb begin
        a_mag   = dividend[15] ? (~dividend + 16'd1) : dividend;
        b_mag   = divisor[15] ? (~divisor + 16'd1) : divisor;
        // partial remainder stays below the divisor magnitude, so 17 bits suffice
        shifted = {prem_q, quo_q[15]};
        diff    = shifted - {1'b0, dmag_q};

        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d   = a_mag;
                    dmag_d  = b_mag;
                    prem_d  = 16'd0;
                    cnt_d   = 5'd16;
                    qneg_d  = dividend[15] ^ divisor[15];
                    rneg_d  = dividend[15];
                    dz_d    = (divisor == 16'd0);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (diff[16]) begin
                    prem_d = shifted[15:0];
                    quo_d  = {quo_q[14:0], 1'b0};
                end else begin
                    prem_d = diff[15:0];
                    quo_d  = {quo_q[14:0], 1'b1};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d = 16'hFFFF;
                end else begin
                    quotient_d = qneg_q ? (~quo_q + 16'd1) : quo_q;
                end
                remainder_d = rneg_q ? (~prem_q + 16'd1) : prem_q;
                dbz_d       = dz_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                cnt_d       = 5'd0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            prem_q      <= 16'd0;
            quo_q       <= 16'd0;
            dmag_q      <= 16'd0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: cycle model built on integer division,
// directed literal checks and randomized property checks.
module tb_seq_signed_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [15:0] divisor = 16'd0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    seq_signed_divider dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    function automatic logic [15:0] exp_q(input logic [15:0] a, input logic [15:0] b);
        int ai, bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) return 16'hFFFF;
        return 16'(ai / bi);
    endfunction

    function automatic logic [15:0] exp_r(input logic [15:0] a, input logic [15:0] b);
        int ai, bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) return a;
        return 16'(ai % bi);
    endfunction

    // Model: an accepted request finishes 17 edges later; idle start is taken.
    logic        m_active = 1'b0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_q = 16'd0;
    logic [15:0] m_r = 16'd0;
    logic        m_dz = 1'b0;
    logic [15:0] m_a = 16'd0;
    logic [15:0] m_b = 16'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_done   <= 1'b0;
            m_q      <= 16'd0;
            m_r      <= 16'd0;
            m_dz     <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 16) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_q      <= exp_q(m_a, m_b);
                    m_r      <= exp_r(m_a, m_b);
                    m_dz     <= (m_b == 16'd0);
                end
            end else if (start) begin
                m_active <= 1'b1;
                m_cnt    <= 0;
                m_a      <= dividend;
                m_b      <= divisor;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            tests++;
            if ({busy, done, quotient, remainder, div_by_zero} !==
                {m_active, m_done, m_q, m_r, m_dz}) begin
                fails++;
                $display("FAIL model cyc=%0d got b=%b d=%b q=%h r=%h z=%b want b=%b d=%b q=%h r=%h z=%b",
                         cyc, busy, done, quotient, remainder, div_by_zero,
                         m_active, m_done, m_q, m_r, m_dz);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done; nbusy counts busy cycles seen including the current one.
    task automatic wait_done(output int nbusy);
        bit ok;
        ok    = 1'b0;
        nbusy = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout waiting for done");
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, output int nbusy);
        issue(a, b);
        wait_done(nbusy);
    endtask

    initial begin
        int nb, t1, t2;
        int ai, bi, qi, ri;

        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, quotient, remainder, div_by_zero}, 32'd0);
        rst = 1'b0;

        run(16'd100, 16'd7, nb);
        chk("100/7 q", quotient, 16'd14);
        chk("100/7 r", remainder, 16'd2);
        chk("100/7 z", div_by_zero, 1'b0);
        chk("100/7 busy_cycles", nb, 17);

        run(-16'sd100, 16'd7, nb);
        chk("-100/7 q", quotient, 16'hFFF2);
        chk("-100/7 r", remainder, 16'hFFFE);

        run(16'd100, -16'sd7, nb);
        chk("100/-7 q", quotient, 16'hFFF2);
        chk("100/-7 r", remainder, 16'd2);

        run(16'd7, 16'd0, nb);
        chk("7/0 q", quotient, 16'hFFFF);
        chk("7/0 r", remainder, 16'd7);
        chk("7/0 z", div_by_zero, 1'b1);
        chk("7/0 busy_cycles", nb, 17);

        run(16'h8000, 16'hFFFF, nb);
        chk("min/-1 q", quotient, 16'h8000);
        chk("min/-1 r", remainder, 16'd0);
        chk("min/-1 z", div_by_zero, 1'b0);

        issue(16'd100, 16'd7);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'd1234;
        divisor  = 16'd3;
        wait_done(nb);
        chk("repulse q", quotient, 16'd14);
        chk("repulse r", remainder, 16'd2);

        run(16'd100, 16'd7, nb);
        t1       = cyc;
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb);
        t2 = cyc;
        chk("b2b spacing", t2 - t1, 18);
        chk("b2b q", quotient, 16'd10);
        chk("b2b r", remainder, 16'd0);

        issue(16'd100, 16'd7);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort outs", {busy, done, quotient, remainder, div_by_zero}, 32'd0);
        rst      = 1'b0;
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        chk("post_rst accept", busy, 1'b1);
        wait_done(nb);
        chk("post_rst q", quotient, 16'd3);
        chk("post_rst r", remainder, 16'd0);

        for (int k = 0; k < 30; k++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (b == 16'd0) b = 16'd1;
            run(a, b, nb);
            ai = int'($signed(a));
            bi = int'($signed(b));
            qi = int'($signed(quotient));
            ri = int'($signed(remainder));
            tests++;
            if (16'(qi * bi + ri) != a ||
                (ri < 0 ? -ri : ri) >= (bi < 0 ? -bi : bi) ||
                (ri != 0 && ((ri < 0) != (ai < 0)))) begin
                fails++;
                $display("FAIL rand_prop a=%h b=%h got q=%h r=%h", a, b, quotient, remainder);
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
